// File: rtl/gpio_debouncer.sv
// gpio_debouncer
// Multi-channel debouncer for switches, buttons and header pins.
// Each in_raw bit is brought into the clock domain through a two-flop
// synchronizer. A per-channel counter then requires DEBOUNCE_CYCLES
// consecutive samples that differ from the committed level before the
// new level is accepted. Any sample that agrees with the committed level
// throws away the progress made so far.
// Registered one-cycle out_rise/out_fall pulses mark every committed change.
//
// Optional feature macro: GPIO_DEBOUNCE_IRQ_EN
//   When defined, this adds sticky per-channel edge flags (irq_pending).
//   Each flag is cleared per channel through irq_clear. A new edge wins
//   over a clear in the same cycle. An OR-reduced irq output is also added.
//   When the macro is undefined, those ports and flags do not exist.

module gpio_debouncer #(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = 1000,
   parameter logic [WIDTH-1:0] INIT_VAL        = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_raw,
   output logic [WIDTH-1:0] out_level,
   output logic [WIDTH-1:0] out_rise,
   output logic [WIDTH-1:0] out_fall
`ifdef GPIO_DEBOUNCE_IRQ_EN
   ,
   input  logic [WIDTH-1:0] irq_clear,
   output logic [WIDTH-1:0] irq_pending,
   output logic             irq
`endif
);

   // Counter just wide enough to hold DEBOUNCE_CYCLES.
   // The counter itself never goes above DEBOUNCE_CYCLES-1.
   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchronizer stages: plain flop-to-flop, no logic in between
   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;

   // Debounce state and registered outputs
   logic [CNT_W-1:0] cnt_r      [WIDTH];
   logic [CNT_W-1:0] cnt_next_s [WIDTH];
   logic [WIDTH-1:0] level_r;
   logic [WIDTH-1:0] level_next_s;
   logic [WIDTH-1:0] rise_r;
   logic [WIDTH-1:0] rise_next_s;
   logic [WIDTH-1:0] fall_r;
   logic [WIDTH-1:0] fall_next_s;
   logic [WIDTH-1:0] differ_s;

   // Two-flop synchronizer for the asynchronous raw inputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= INIT_VAL;
         sync2_r <= INIT_VAL;
      end else begin
         sync1_r <= in_raw;
         sync2_r <= sync1_r;
      end
   end

   // Per-channel debounce decision: clear, count up, or commit
   always_comb begin
      differ_s     = sync2_r ^ level_r;
      level_next_s = level_r;
      rise_next_s  = {WIDTH{1'b0}};
      fall_next_s  = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next_s[i] = CNT_ZERO;
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (!differ_s[i]) begin
            // The sample agrees with the committed level: drop any partial progress.
            cnt_next_s[i] = CNT_ZERO;
         end else if (cnt_r[i] >= CNT_LAST) begin
            // Last required differing sample: accept the new level and re-arm.
            // Using >= rather than == means the counter cannot run past the limit.
            cnt_next_s[i]   = CNT_ZERO;
            level_next_s[i] = sync2_r[i];
            rise_next_s[i]  = sync2_r[i];
            fall_next_s[i]  = ~sync2_r[i];
         end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_ONE;
         end
      end
   end

   // Debounce state and pulse registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
         level_r <= INIT_VAL;
         rise_r  <= {WIDTH{1'b0}};
         fall_r  <= {WIDTH{1'b0}};
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
         level_r <= level_next_s;
         rise_r  <= rise_next_s;
         fall_r  <= fall_next_s;
      end
   end

   assign out_level = level_r;
   assign out_rise  = rise_r;
   assign out_fall  = fall_r;

`ifdef GPIO_DEBOUNCE_IRQ_EN
   logic [WIDTH-1:0] pending_r;
   logic [WIDTH-1:0] pending_next_s;

   // Sticky edge capture. A new edge is OR-ed in after the clear, so a
   // coincident edge keeps the flag set.
   always_comb begin
      pending_next_s = (pending_r & ~irq_clear) | rise_next_s | fall_next_s;
   end

   // Pending flag register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_r <= {WIDTH{1'b0}};
      end else begin
         pending_r <= pending_next_s;
      end
   end

   assign irq_pending = pending_r;
   assign irq         = |pending_r;
`endif

endmodule
